// File: rtl/bist_controller_param_if.sv
// Control/status bundle between top-level test control (master) and the BIST sequencer (slave).
// Defining BIST_FAIL_CNT_EN adds the fail_count status field.
interface bist_controller_param_if #(
    parameter int SIG_W = 16,
    parameter int CNT_W = 3
);
    logic             start_bist;
    logic             abort;
    logic [SIG_W-1:0] signature;
    logic [SIG_W-1:0] golden;
    logic             init;
    logic             en;
    logic             compare;
    logic             pass_fail;
    logic             done;
    logic             busy;
    logic [CNT_W-1:0] pattern_idx;
    logic [2:0]       state;
`ifdef BIST_FAIL_CNT_EN
    logic [7:0]       fail_count;

    modport master (
        output start_bist, abort, signature, golden,
        input  init, en, compare, pass_fail, done, busy, pattern_idx, state, fail_count
    );
    modport slave (
        input  start_bist, abort, signature, golden,
        output init, en, compare, pass_fail, done, busy, pattern_idx, state, fail_count
    );
`else
    modport master (
        output start_bist, abort, signature, golden,
        input  init, en, compare, pass_fail, done, busy, pattern_idx, state
    );
    modport slave (
        input  start_bist, abort, signature, golden,
        output init, en, compare, pass_fail, done, busy, pattern_idx, state
    );
`endif
endinterface

// File: rtl/bist_controller_param.sv
// Parametrised BIST sequencer: INIT -> RUN (NUM_PATTERNS en cycles) -> SETTLE -> COMPARE -> DONE.
// Optional macro BIST_FAIL_CNT_EN adds a saturating 8-bit mismatch counter (cleared only by rst).
module bist_controller_param #(
    parameter int  NUM_PATTERNS = 8,
    parameter int  LATENCY      = 2,
    parameter int  SIG_W        = 16,
    localparam int CNT_W        = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1,
    localparam int LAT_W        = (LATENCY > 1) ? $clog2(LATENCY) : 1
) (
    input logic                    clk,
    input logic                    rst,
    bist_controller_param_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INIT    = 3'd1,
        S_RUN     = 3'd2,
        S_SETTLE  = 3'd3,
        S_COMPARE = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t           r_state;
    logic             r_init;
    logic             r_en;
    logic             r_compare;
    logic             r_pass_fail;
    logic             r_done;
    logic             r_busy;
    logic [CNT_W-1:0] r_idx;
    logic [LAT_W-1:0] r_settle;

    logic [SIG_W-1:0] w_sig;
    logic [SIG_W-1:0] w_gold;
    logic             w_match;
    logic             w_last;
    logic             w_enter_cmp;

    assign w_sig   = bus.signature;
    assign w_gold  = bus.golden;
    assign w_match = (w_sig == w_gold);
    assign w_last  = (r_idx == CNT_W'(NUM_PATTERNS - 1));

    // Edge on which compare rises; shared by the FSM and the mismatch counter.
    assign w_enter_cmp = !bus.abort &&
                         (((r_state == S_RUN) && w_last && (LATENCY == 0)) ||
                          ((r_state == S_SETTLE) && (r_settle == '0)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_init      <= 1'b0;
            r_en        <= 1'b0;
            r_compare   <= 1'b0;
            r_pass_fail <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_idx       <= '0;
            r_settle    <= '0;
        end else if (bus.abort) begin
            r_state     <= S_IDLE;
            r_init      <= 1'b0;
            r_en        <= 1'b0;
            r_compare   <= 1'b0;
            r_pass_fail <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_idx       <= '0;
            r_settle    <= '0;
        end else begin
            if (w_enter_cmp) begin
                r_state     <= S_COMPARE;
                r_compare   <= 1'b1;
                r_pass_fail <= w_match;
            end
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start_bist) begin
                        r_state     <= S_INIT;
                        r_init      <= 1'b1;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_pass_fail <= 1'b0;
                    end
                end
                S_INIT: begin
                    if (!bus.start_bist) begin
                        r_state <= S_RUN;
                        r_init  <= 1'b0;
                        r_en    <= 1'b1;
                        r_idx   <= '0;
                    end
                end
                S_RUN: begin
                    if (w_last) begin
                        r_en  <= 1'b0;
                        r_idx <= '0;
                        if (LATENCY > 0) begin
                            r_state  <= S_SETTLE;
                            r_settle <= LAT_W'(LATENCY - 1);
                        end
                    end else begin
                        r_idx <= r_idx + CNT_W'(1);
                    end
                end
                S_SETTLE: begin
                    if (r_settle != '0) begin
                        r_settle <= r_settle - LAT_W'(1);
                    end
                end
                S_COMPARE: begin
                    r_state   <= S_DONE;
                    r_compare <= 1'b0;
                    r_done    <= 1'b1;
                    r_busy    <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef BIST_FAIL_CNT_EN
    logic [7:0] r_fail_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fail_cnt <= 8'd0;
        end else if (w_enter_cmp && !w_match && (r_fail_cnt != 8'hFF)) begin
            r_fail_cnt <= r_fail_cnt + 8'd1;
        end
    end

    assign bus.fail_count = r_fail_cnt;
`endif

    assign bus.init        = r_init;
    assign bus.en          = r_en;
    assign bus.compare     = r_compare;
    assign bus.pass_fail   = r_pass_fail;
    assign bus.done        = r_done;
    assign bus.busy        = r_busy;
    assign bus.pattern_idx = r_idx;
    assign bus.state       = r_state;
endmodule

// File: doc/bist_controller_param.md
Name: bist_controller_param

Overview:
- Parametrised BIST sequencer: drives the pattern generator (init/en) and output-response analyser of a circuit under test, then compares the captured signature against a golden value.
- Generalises the fixed 3-pattern, 1-bit-result controller. Adds configurable pattern count, CUT/ORA pipeline settle latency, multi-bit signature compare, abort, done/busy status and pattern index.
- Sits between the top-level test control and the TPG/CUT/MISR datapath.

Parameters:
- NUM_PATTERNS, 8, number of cycles en is asserted (>=1)
- LATENCY, 2, settle cycles after last pattern before compare (>=0; covers CUT+MISR pipeline)
- SIG_W, 16, signature width in bits (>=1)
- CNT_W, $clog2(NUM_PATTERNS) min 1, pattern counter width (derived, not overridden)

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- start_bist  input  1  level request; held high = initialise, falling level = launch run
- abort  input  1  synchronous abort, returns to IDLE
- signature  input  SIG_W  MISR signature from ORA
- golden  input  SIG_W  expected signature, sampled only in COMPARE
- init  output  1  TPG/MISR seed load
- en  output  1  TPG/MISR advance enable
- compare  output  1  one-cycle compare strobe
- pass_fail  output  1  1 = signature matched golden (pass), 0 = fail/not yet evaluated
- done  output  1  session complete, result valid
- busy  output  1  high in INIT, RUN, SETTLE, COMPARE
- pattern_idx  output  CNT_W  index of current pattern while en=1 (0..NUM_PATTERNS-1), else 0

Behaviour:
- All outputs registered. On rst: state=IDLE, every output 0, counters 0.
- FSM states: IDLE, INIT, RUN, SETTLE, COMPARE, DONE.
- IDLE: start_bist=1 -> INIT.
- DONE: start_bist=1 -> INIT, clearing done and pass_fail.
- INIT: init=1, en=0, busy=1. Stays while start_bist=1. start_bist sampled 0 -> RUN; init=0, en=1, pattern_idx=0.
- RUN: en=1 for exactly NUM_PATTERNS consecutive cycles; pattern_idx increments by 1 each cycle. At pattern_idx==NUM_PATTERNS-1 the next edge leaves RUN:
  - to SETTLE if LATENCY>0
  - to COMPARE if LATENCY=0
  - en=0 and pattern_idx=0 on that edge.
- SETTLE: en=0 for exactly LATENCY cycles (down-counter), then -> COMPARE.
- COMPARE: compare=1 for exactly one cycle. pass_fail is registered as (signature==golden), updating on the same edge compare rises. Next edge: compare=0, done=1, busy=0, -> DONE.
- DONE: done=1 and pass_fail held until start_bist=1, abort, or rst.
- start_bist in RUN/SETTLE/COMPARE: ignored, run not restarted.
- abort=1 in any state: next edge -> IDLE, all outputs 0 (pass_fail and done cleared). abort has priority over start_bist.
- rst mid-run: immediate return to IDLE, all outputs 0; no partial result retained.
- Total latency from start_bist sampled low in INIT to done=1: NUM_PATTERNS+LATENCY+1 cycles.
- Counter arithmetic: no wrap. pattern_idx never exceeds NUM_PATTERNS-1; NUM_PATTERNS=1 gives a single en cycle.

Optional Feature:
- Macro: BIST_FAIL_CNT_EN.
- Defined:
  - Adds output fail_count [7:0].
  - Increments by 1 on each COMPARE with a mismatch; saturates at 255.
  - Cleared only by rst; not cleared by abort or a new start.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- NUM_PATTERNS=8, LATENCY=2, SIG_W=16; rst pulse, start_bist high 3 cycles then low; signature=golden=16'hA5C3 -> init high 3 cycles, en high exactly 8 cycles (pattern_idx 0..7), 2 idle cycles, compare high 1 cycle, pass_fail=1, done=1 eleven cycles after start_bist sampled low.
- Same run with signature=16'hA5C2, golden=16'hA5C3 -> pass_fail=0, done=1; with BIST_FAIL_CNT_EN, fail_count=1; a second failing run gives fail_count=2.
- abort=1 on the 4th en cycle -> next cycle en=0, busy=0, done=0, pass_fail=0, state IDLE; a subsequent start runs a full 8 patterns.
- start_bist pulsed high during RUN -> no effect, en count still 8. start_bist high in DONE -> done and pass_fail drop, init=1.
- LATENCY=0, NUM_PATTERNS=1 -> en high 1 cycle, compare on the immediately following cycle, done one cycle later.
- rst asserted asynchronously mid-SETTLE -> all outputs 0 without waiting for a clk edge; with BIST_FAIL_CNT_EN, fail_count=0.
